gray_codec: RTL and testbench

Parametrised, bidirectional Gray-code converter. It is the successor to the single-direction binary-to-Gray block. Each accepted beat carries its own direction: binary→Gray or Gray→binary. The datapath is a 2-stage valid/ready pipeline with full backpressure, and it sits in front of CDC pointer logic and encoder interfaces wherever Gray conversion is needed at streaming rate.

---
 rtl/gray_codec.sv | 169 ++++++++++++++++
 tb/tb_gray_codec.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_codec.sv
// gray_codec: bidirectional Gray-code converter, 2-stage valid/ready pipeline.
// Each accepted beat carries its own direction (i_mode: 0 = bin->Gray,
// 1 = Gray->bin); order is preserved and throughput is one beat per cycle.
//
// Parameters:
//   MSB   - data width in bits (>= 2)
//   CNT_W - width of the accepted-beat counter
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_en      - input beat valid          o_rdy   - can accept (comb. from i_rdy)
//   i_mode    - beat direction            i_data  - input word
//   o_valid   - output beat valid         i_rdy   - downstream ready
//   o_mode    - direction tag of o_data   o_data  - converted word
//   o_count   - accepted-beat count, wraps modulo 2^CNT_W
//   o_adj_err - (GRAY_CODEC_ADJ_CHECK_EN only) Gray input was not at Hamming
//               distance 1 from the previous accepted Gray input
//
// Build option: define GRAY_CODEC_ADJ_CHECK_EN to add the adjacency checker.
module gray_codec #(
    parameter int unsigned MSB   = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic             o_rdy,
    input  logic             i_mode,
    input  logic [MSB-1:0]   i_data,
    output logic             o_valid,
    input  logic             i_rdy,
    output logic             o_mode,
    output logic [MSB-1:0]   o_data,
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    output logic             o_adj_err,
`endif
    output logic [CNT_W-1:0] o_count
);

    // Binary -> Gray
    function automatic logic [MSB-1:0] bin2gray(input logic [MSB-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [MSB-1:0] gray2bin(input logic [MSB-1:0] g);
        logic [MSB-1:0] b;
        b = '0;
        for (int unsigned k = 0; k < MSB; k++) begin
            b[k] = ^(g >> k);
        end
        return b;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic             s1_mode_q,  s1_mode_d;
    logic [MSB-1:0]   s1_data_q,  s1_data_d;
    logic             o_valid_q,  o_valid_d;
    logic             o_mode_q,   o_mode_d;
    logic [MSB-1:0]   o_data_q,   o_data_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv = ~o_valid_q | i_rdy;
    assign s1_adv = ~s1_valid_q | s2_adv;
    assign accept = i_en & s1_adv;

`ifdef GRAY_CODEC_ADJ_CHECK_EN
    logic           s1_err_q,  s1_err_d;
    logic           adj_err_q, adj_err_d;
    logic [MSB-1:0] ref_q,     ref_d;
    logic           ref_v_q,   ref_v_d;
    logic           in_err;

    // A repeat (distance 0) counts as an error; the first Gray beat has no reference
    assign in_err = ref_v_q && ($countones(i_data ^ ref_q) != 1);
`endif

    // Next-state logic for both stages and the counter
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        o_valid_d  = o_valid_q;
        o_mode_d   = o_mode_q;
        o_data_d   = o_data_q;
        count_d    = count_q;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
        s1_err_d   = s1_err_q;
        adj_err_d  = adj_err_q;
        ref_d      = ref_q;
        ref_v_d    = ref_v_q;
`endif

        if (s1_adv) begin
            s1_valid_d = i_en;
        end
        if (accept) begin
            s1_mode_d = i_mode;
            s1_data_d = i_data;
            count_d   = count_q + CNT_W'(1);
`ifdef GRAY_CODEC_ADJ_CHECK_EN
            // Binary->Gray beats neither flag nor move the reference
            s1_err_d = i_mode & in_err;
            if (i_mode) begin
                ref_d   = i_data;
                ref_v_d = 1'b1;
            end
`endif
        end

        if (s2_adv) begin
            o_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                o_mode_d = s1_mode_q;
                o_data_d = s1_mode_q ? gray2bin(s1_data_q) : bin2gray(s1_data_q);
`ifdef GRAY_CODEC_ADJ_CHECK_EN
                adj_err_d = s1_err_q;
`endif
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
            o_valid_q  <= 1'b0;
            o_mode_q   <= 1'b0;
            o_data_q   <= '0;
            count_q    <= '0;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
            s1_err_q   <= 1'b0;
            adj_err_q  <= 1'b0;
            ref_q      <= '0;
            ref_v_q    <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            o_valid_q  <= o_valid_d;
            o_mode_q   <= o_mode_d;
            o_data_q   <= o_data_d;
            count_q    <= count_d;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
            s1_err_q   <= s1_err_d;
            adj_err_q  <= adj_err_d;
            ref_q      <= ref_d;
            ref_v_q    <= ref_v_d;
`endif
        end
    end

    assign o_rdy   = s1_adv;
    assign o_valid = o_valid_q;
    assign o_mode  = o_mode_q;
    assign o_data  = o_data_q;
    assign o_count = count_q;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    assign o_adj_err = adj_err_q;
`endif

endmodule

// File: tb/tb_gray_codec.sv
// Directed bench for gray_codec (MSB=4). A second instance with CNT_W=4
// shares all inputs to observe counter wrap.
module tb_gray_codec;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic        i_mode;
    logic [3:0]  i_data;
    logic        i_rdy;
    logic        o_rdy,   o_rdy4;
    logic        o_valid, o_valid4;
    logic        o_mode,  o_mode4;
    logic [3:0]  o_data,  o_data4;
    logic [15:0] o_count;
    logic [3:0]  o_count4;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    logic        o_adj_err, o_adj_err4;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_codec #(.MSB(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .i_en(i_en), .o_rdy(o_rdy), .i_mode(i_mode),
        .i_data(i_data), .o_valid(o_valid), .i_rdy(i_rdy), .o_mode(o_mode),
        .o_data(o_data),
`ifdef GRAY_CODEC_ADJ_CHECK_EN
        .o_adj_err(o_adj_err),
`endif
        .o_count(o_count)
    );

    gray_codec #(.MSB(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_en(i_en), .o_rdy(o_rdy4), .i_mode(i_mode),
        .i_data(i_data), .o_valid(o_valid4), .i_rdy(i_rdy), .o_mode(o_mode4),
        .o_data(o_data4),
`ifdef GRAY_CODEC_ADJ_CHECK_EN
        .o_adj_err(o_adj_err4),
`endif
        .o_count(o_count4)
    );

    // Hand-computed binary->Gray table for 0..15
    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    logic       in_mode  [$];
    logic [3:0] in_data  [$];
    logic       exp_mode [$];
    logic [3:0] exp_data [$];
    logic       exp_adj  [$];

    int first_valid;
    int rdy_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        in_mode.delete();
        in_data.delete();
        exp_mode.delete();
        exp_data.delete();
        exp_adj.delete();
    endtask

    // Drives in_* back to back, holds i_rdy low on cycles flagged in stall_mask,
    // and checks every consumed beat plus stability of o_data/o_mode during stalls.
    task automatic stream(input string tag, input logic [31:0] stall_mask);
        int         idx = 0;
        int         got = 0;
        int         cyc = 0;
        logic       acc;
        logic       held_v = 1'b0;
        logic [3:0] held_d = '0;
        logic       held_m = 1'b0;
        first_valid = -1;
        rdy_low     = 0;
        while (got < exp_data.size() && cyc < 200) begin
            i_rdy = (cyc < 32) ? ~stall_mask[cyc] : 1'b1;
            if (idx < in_data.size()) begin
                i_en   = 1'b1;
                i_mode = in_mode[idx];
                i_data = in_data[idx];
            end else begin
                i_en = 1'b0;
            end
            #1;
            if (held_v) begin
                chk({tag, "_hold_data"}, 32'(o_data), 32'(held_d));
                chk({tag, "_hold_mode"}, 32'(o_mode), 32'(held_m));
            end
            if (o_valid && first_valid < 0) first_valid = cyc;
            if (!o_rdy) rdy_low++;
            acc = i_en && o_rdy;
            if (o_valid && i_rdy) begin
                chk($sformatf("%s_data%0d", tag, got), 32'(o_data), 32'(exp_data[got]));
                chk($sformatf("%s_mode%0d", tag, got), 32'(o_mode), 32'(exp_mode[got]));
`ifdef GRAY_CODEC_ADJ_CHECK_EN
                if (got < exp_adj.size())
                    chk($sformatf("%s_adj%0d", tag, got), 32'(o_adj_err), 32'(exp_adj[got]));
`endif
                got++;
            end
            held_v = o_valid && !i_rdy;
            held_d = o_data;
            held_m = o_mode;
            tick();
            if (acc) idx++;
            cyc++;
        end
        i_en  = 1'b0;
        i_rdy = 1'b1;
        chk({tag, "_beats_out"}, 32'(got), 32'(exp_data.size()));
    endtask

    initial begin
        int v;
        int vcnt;
        rst    = 1'b1;
        i_en   = 1'b0;
        i_mode = 1'b0;
        i_data = '0;
        i_rdy  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data",  32'(o_data),  32'd0);
        chk("rst_mode",  32'(o_mode),  32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_rdy",   32'(o_rdy),   32'd1);
`ifdef GRAY_CODEC_ADJ_CHECK_EN
        chk("rst_adj",   32'(o_adj_err), 32'd0);
`endif

        // Sweep bin->Gray 0..15
        clear_q();
        for (int i = 0; i < 16; i++) begin
            in_mode.push_back(1'b0);  in_data.push_back(4'(i));
            exp_mode.push_back(1'b0); exp_data.push_back(gray_tab[i]);
        end
        stream("sweep", 32'h0);
        chk("sweep_latency", 32'(first_valid), 32'd2);
        chk("sweep_count",   32'(o_count),  32'd16);
        chk("sweep_count4",  32'(o_count4), 32'd0);

        // One more beat: 17 total, narrow counter wraps to 1
        clear_q();
        in_mode.push_back(1'b0);  in_data.push_back(4'h3);
        exp_mode.push_back(1'b0); exp_data.push_back(4'h2);
        stream("wrap", 32'h0);
        chk("wrap_count",  32'(o_count),  32'd17);
        chk("wrap_count4", 32'(o_count4), 32'd1);

        // Inverse sweep Gray->bin, plus spot check 1000 -> 1111
        clear_q();
        for (int i = 0; i < 16; i++) begin
            in_mode.push_back(1'b1);  in_data.push_back(gray_tab[i]);
            exp_mode.push_back(1'b1); exp_data.push_back(4'(i));
        end
        in_mode.push_back(1'b1);  in_data.push_back(4'b1000);
        exp_mode.push_back(1'b1); exp_data.push_back(4'b1111);
        stream("inv", 32'h0);
        chk("inv_count", 32'(o_count), 32'd34);

        // Round trip of random values through the Gray table
        clear_q();
        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(15, 0));
            in_mode.push_back(1'b1);  in_data.push_back(gray_tab[v]);
            exp_mode.push_back(1'b1); exp_data.push_back(4'(v));
        end
        stream("rtrip", 32'h0);

        // Backpressure: 8 beats, i_rdy low on cycles 3..6
        clear_q();
        for (int i = 0; i < 8; i++) begin
            in_mode.push_back(1'b0);  in_data.push_back(4'(i));
            exp_mode.push_back(1'b0); exp_data.push_back(gray_tab[i]);
        end
        stream("bp", 32'h0000_0078);
        chk("bp_rdy_low_cycles", 32'(rdy_low), 32'd4);
        chk("bp_count", 32'(o_count), 32'd48);

        // Mixed modes
        clear_q();
        in_mode.push_back(1'b0); in_data.push_back(4'h5);
        in_mode.push_back(1'b1); in_data.push_back(4'h5);
        in_mode.push_back(1'b0); in_data.push_back(4'hF);
        in_mode.push_back(1'b1); in_data.push_back(4'hF);
        exp_mode.push_back(1'b0); exp_data.push_back(4'h7);
        exp_mode.push_back(1'b1); exp_data.push_back(4'h6);
        exp_mode.push_back(1'b0); exp_data.push_back(4'h8);
        exp_mode.push_back(1'b1); exp_data.push_back(4'hA);
        stream("mixed", 32'h0);

        // Reset with two beats in flight (held by i_rdy=0)
        i_rdy  = 1'b0;
        i_en   = 1'b1;
        i_mode = 1'b0;
        i_data = 4'h5;
        tick();
        i_data = 4'h6;
        tick();
        i_en = 1'b0;
        #1;
        chk("mid_inflight_valid", 32'(o_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        i_rdy = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_count", 32'(o_count), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_valid) vcnt++;
        end
        chk("mid_rst_no_ghost", 32'(vcnt), 32'd0);

        clear_q();
        in_mode.push_back(1'b0);  in_data.push_back(4'h9);
        exp_mode.push_back(1'b0); exp_data.push_back(4'hD);
        stream("post_rst", 32'h0);
        chk("post_rst_count", 32'(o_count), 32'd1);

`ifdef GRAY_CODEC_ADJ_CHECK_EN
        // Adjacency: 0000,0001,0011,0000,0000 -> errors 0,0,0,1,1
        clear_q();
        in_mode.push_back(1'b1); in_data.push_back(4'h0);
        in_mode.push_back(1'b1); in_data.push_back(4'h1);
        in_mode.push_back(1'b0); in_data.push_back(4'hF);
        in_mode.push_back(1'b1); in_data.push_back(4'h3);
        in_mode.push_back(1'b1); in_data.push_back(4'h0);
        in_mode.push_back(1'b1); in_data.push_back(4'h0);
        exp_mode.push_back(1'b1); exp_data.push_back(4'h0); exp_adj.push_back(1'b0);
        exp_mode.push_back(1'b1); exp_data.push_back(4'h1); exp_adj.push_back(1'b0);
        exp_mode.push_back(1'b0); exp_data.push_back(4'h8); exp_adj.push_back(1'b0);
        exp_mode.push_back(1'b1); exp_data.push_back(4'h2); exp_adj.push_back(1'b0);
        exp_mode.push_back(1'b1); exp_data.push_back(4'h0); exp_adj.push_back(1'b1);
        exp_mode.push_back(1'b1); exp_data.push_back(4'h0); exp_adj.push_back(1'b1);
        stream("adj", 32'h0000_0030);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
